// File: rtl/sum_share_pkg.sv
// Shared definitions for the sum_fsm sharing arbiter: FSM state encoding,
// IEEE-754 single constants and the wait-counter width.
package sum_share_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  localparam logic [31:0] FP_ONE  = 32'h3F80_0000;
  localparam logic [31:0] FP_ZERO = 32'h0000_0000;

  // width of the optional WAIT watchdog counter
  localparam int WAIT_CNT_W = 16;

endpackage

// File: rtl/sum_share_arb_rr_pick.sv
// Combinational round-robin selector: returns the first pending index
// searching last+1, last+2, ... (modulo N_REQ).
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] pending,
  input  logic [IDX_W-1:0] last,
  output logic [IDX_W-1:0] grant,
  output logic             grant_valid
);

  logic [IDX_W-1:0] cand;

  // walk from the farthest candidate back to last+1 so the nearest one wins
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    cand        = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = IDX_W'((int'(last) + k) % N_REQ);
      if (pending[cand]) begin
        grant       = cand;
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sum_share_arb.sv
// sum_share_arb: round-robin sharing of one external sum_fsm adder between
// N_REQ requesters. Operands are latched per requester, issued with a
// one-cycle add_ri pulse and the result returned with a per-requester
// req_done pulse. Nothing is computed here; data passes through unchanged.
//
// Optional build macro SUM_SHARE_ARB_TIMEOUT_EN: adds a WAIT watchdog that
// aborts after TIMEOUT_CYC cycles with res=0 and a req_err pulse.
// Without it WAIT is unbounded and req_err is always 0.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no service in flight; pick next pending requester
// ST_ISSUE | add_ri pulse with the granted operands
// ST_WAIT  | operands held; waiting for add_ro (or watchdog)
// ST_DONE  | req_done[grant] pulse, res valid; grant retired
module sum_share_arb
  import sum_share_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      req_ri,
  input  logic [32*N_REQ-1:0]   req_a,
  input  logic [32*N_REQ-1:0]   req_b,
  output logic [N_REQ-1:0]      req_busy,
  output logic [N_REQ-1:0]      req_done,
  output logic [N_REQ-1:0]      req_err,
  output logic [31:0]           res,
  output logic                  add_ri,
  output logic [31:0]           add_a,
  output logic [31:0]           add_b,
  input  logic                  add_ro,
  input  logic [31:0]           add_res
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_REQ - 1);

  if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
    $error("sum_share_arb: N_REQ must be within 2..8");
  end
  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
    $error("sum_share_arb: TIMEOUT_CYC must be within 1..65535");
  end

  state_t           state, state_nxt;
  logic [N_REQ-1:0] pending;
  logic [31:0]      op_a [N_REQ];
  logic [31:0]      op_b [N_REQ];
  logic [IDX_W-1:0] grant_q;
  logic [IDX_W-1:0] last_q;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_valid;
  logic [31:0]      res_q;
  logic             timeout_hit;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .pending     (pending),
    .last        (last_q),
    .grant       (pick_idx),
    .grant_valid (pick_valid)
  );

`ifdef SUM_SHARE_ARB_TIMEOUT_EN
  logic [WAIT_CNT_W-1:0] wait_cnt;
  logic                  err_q;

  // watchdog: cleared on ISSUE, counts WAIT cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (state == ST_ISSUE) begin
      wait_cnt <= '0;
    end else if (state == ST_WAIT) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // the count would reach TIMEOUT_CYC at this edge; a real add_ro wins
  assign timeout_hit = (state == ST_WAIT) && !add_ro &&
                       (wait_cnt == WAIT_CNT_W'(TIMEOUT_CYC - 1));

  // remember that the current service ended by abort
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (state == ST_ISSUE) begin
      err_q <= 1'b0;
    end else if (timeout_hit) begin
      err_q <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (pick_valid) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT:  if (add_ro || timeout_hit) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // operand latches; a busy requester's operands are never overwritten
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (req_ri[i] && !pending[i]) begin
        op_a[i] <= req_a[32*i +: 32];
        op_b[i] <= req_b[32*i +: 32];
      end
    end
  end

  // pending set, grant, round-robin pointer and result capture
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
      grant_q <= '0;
      last_q  <= LAST_RST;
      res_q   <= FP_ZERO;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (req_ri[i] && !pending[i]) begin
          pending[i] <= 1'b1;
        end
      end
      if (state == ST_IDLE && pick_valid) begin
        grant_q <= pick_idx;
      end
      if (state == ST_WAIT) begin
        if (add_ro) begin
          res_q <= add_res;
        end else if (timeout_hit) begin
          res_q <= FP_ZERO;
        end
      end
      // the granted bit is still set here, so a same-cycle re-request
      // from the granted requester was not captured above
      if (state == ST_DONE) begin
        pending[grant_q] <= 1'b0;
        last_q           <= grant_q;
      end
    end
  end

  // outputs decoded from state and grant
  always_comb begin
    add_ri   = (state == ST_ISSUE);
    add_a    = '0;
    add_b    = '0;
    req_done = '0;
    req_err  = '0;
    if (state == ST_ISSUE || state == ST_WAIT) begin
      add_a = op_a[grant_q];
      add_b = op_b[grant_q];
    end
    if (state == ST_DONE) begin
      req_done[grant_q] = 1'b1;
`ifdef SUM_SHARE_ARB_TIMEOUT_EN
      req_err[grant_q]  = err_q;
`endif
    end
  end

  assign req_busy = pending;
  assign res      = res_q;

endmodule

// File: tb/tb_sum_share_arb.sv
// Self-checking bench for sum_share_arb with a stand-in adder.
// A reference model tracks pending requests and round-robin order,
// pushes the expected completion at each observed issue, and a separate
// monitor pops and compares on every req_done pulse.
`timescale 1ns/1ps
module tb_sum_share_arb;
  import sum_share_pkg::*;

  localparam int N = 4;
`ifdef SUM_SHARE_ARB_TIMEOUT_EN
  localparam int TO_CYC = 8;
`else
  localparam int TO_CYC = 64;
`endif

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req_ri = '0;
  logic [32*N-1:0] req_a = '0;
  logic [32*N-1:0] req_b = '0;
  logic [N-1:0]   req_busy, req_done, req_err;
  logic [31:0]    res, add_a, add_b;
  logic           add_ri;
  logic           add_ro = 1'b0;
  logic [31:0]    add_res = '0;

  sum_share_arb #(.N_REQ(N), .TIMEOUT_CYC(TO_CYC)) dut (
    .clk(clk), .reset(reset), .req_ri(req_ri), .req_a(req_a), .req_b(req_b),
    .req_busy(req_busy), .req_done(req_done), .req_err(req_err), .res(res),
    .add_ri(add_ri), .add_a(add_a), .add_b(add_b), .add_ro(add_ro),
    .add_res(add_res)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // stand-in adder: exact sums for the known pairs, a tag function otherwise
  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    if ((a == FP_ONE && b == 32'h4000_0000) || (a == 32'h4000_0000 && b == FP_ONE))
      return 32'h4040_0000;
    if (a == FP_ONE && b == FP_ONE)
      return 32'h4000_0000;
    return a ^ {b[15:0], b[31:16]} ^ 32'h5A5A_0000;
  endfunction

  function automatic int rr_next(input logic [N-1:0] p, input int last);
    for (int k = 1; k <= N; k++) begin
      if (p[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  typedef struct {
    int          idx;
    logic [31:0] res;
    logic        err;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  // reference model state
  logic [N-1:0] m_pend = '0;
  int           m_last = N - 1;
  bit           m_srv = 0;
  int           m_g = 0;
  bit           exp_issue = 0;
  logic [31:0]  m_a [N];
  logic [31:0]  m_b [N];
  int           n_issue = 0;
  logic [N-1:0] cap;
  int           lat;
  exp_t         e;

  // adder control
  bit           adder_mute = 0;
  int           lat_fixed = 0;
  bit           pend_resp = 0;
  int           resp_cnt = 0;
  logic [31:0]  resp_val = '0;
  bit           stray_req = 0;

  // monitor statistics
  int           done_cnt [N] = '{default: 0};
  int           n_done = 0;
  int           n_err = 0;
  logic [31:0]  last_res = '0;
  int           done_log[$];
  exp_t         e2;
  logic [N-1:0] oh;

  // reference model: pending set, round-robin order, issue checks
  always @(negedge clk) begin
    if (reset) begin
      m_pend = '0; m_last = N - 1; m_srv = 0; exp_issue = 0;
      pend_resp = 0; sb.delete();
    end else begin
      if (exp_issue) chk("issue_after_idle", 32'(add_ri), 32'd1);
      exp_issue = 0;
      chk("busy", 32'(req_busy), 32'(m_pend));
      if (add_ri) begin
        chk("issue_overlap", 32'(m_srv), 32'd0);
        m_g = rr_next(m_pend, m_last);
        if (m_g < 0) begin
          chk("issue_without_pending", 32'(add_ri), 32'd0);
        end else begin
          chk("issue_a", add_a, m_a[m_g]);
          chk("issue_b", add_b, m_b[m_g]);
          m_srv = 1;
          n_issue++;
          if (!adder_mute) begin
            lat = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 6));
            pend_resp = 1; resp_cnt = lat - 1; resp_val = fadd(add_a, add_b);
            e.idx = m_g; e.res = fadd(m_a[m_g], m_b[m_g]); e.err = 1'b0;
            e.cyc = cyc + lat + 1;
            sb.push_back(e);
          end else begin
`ifdef SUM_SHARE_ARB_TIMEOUT_EN
            e.idx = m_g; e.res = FP_ZERO; e.err = 1'b1; e.cyc = cyc + TO_CYC + 1;
            sb.push_back(e);
`endif
          end
        end
      end else if (m_srv && req_done == '0) begin
        chk("wait_a_stable", add_a, m_a[m_g]);
        chk("wait_b_stable", add_b, m_b[m_g]);
      end
      if (!m_srv && m_pend != '0) exp_issue = 1;
      cap = req_ri & ~m_pend;
      if (req_done != '0 && m_srv) begin
        m_pend[m_g] = 1'b0;
        m_last = m_g;
        m_srv = 0;
      end
      for (int i = 0; i < N; i++) begin
        if (cap[i]) begin
          m_pend[i] = 1'b1;
          m_a[i] = req_a[32*i +: 32];
          m_b[i] = req_b[32*i +: 32];
        end
      end
    end
  end

  // scoreboard monitor: pops on every done pulse
  always @(negedge clk) begin
    if (!reset) begin
      if (req_done != '0) begin
        n_done++;
        for (int i = 0; i < N; i++) begin
          if (req_done[i]) begin
            done_cnt[i]++;
            done_log.push_back(i);
          end
        end
        if (req_err != '0) n_err++;
        last_res = res;
        if (sb.size() == 0) begin
          chk("done_unexpected", 32'(req_done), 32'd0);
        end else begin
          e2 = sb.pop_front();
          oh = '0;
          oh[e2.idx] = 1'b1;
          chk("done_idx", 32'(req_done), 32'(oh));
          chk("done_res", res, e2.res);
          chk("done_err", 32'(req_err), e2.err ? 32'(oh) : 32'd0);
          chk("done_cycle", 32'(cyc), 32'(e2.cyc));
        end
      end else if (req_err != '0) begin
        n_err++;
        chk("err_without_done", 32'(req_err), 32'd0);
      end
    end
  end

  // stand-in sum_fsm: drives add_ro/add_res just after the clock edge
  initial begin
    forever begin
      @(posedge clk); #1;
      add_ro = 1'b0;
      if (pend_resp) begin
        if (resp_cnt == 0) begin
          add_ro = 1'b1; add_res = resp_val; pend_resp = 0;
        end else begin
          resp_cnt--;
        end
      end
      if (stray_req) begin
        add_ro = 1'b1; add_res = 32'hDEAD_BEEF; stray_req = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
  endtask

  task automatic pulse(input logic [N-1:0] mask);
    tick(); req_ri = mask;
    tick(); req_ri = '0;
  endtask

  task automatic do_reset();
    tick(); reset = 1'b1;
    tick(); tick(); reset = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while ((m_pend != '0 || m_srv || sb.size() != 0) && n < budget) begin
      @(negedge clk); n++;
    end
    chk({name, "_idle_timeout"}, 32'(n >= budget), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_quiet(input string name);
    chk({name, "_busy"}, 32'(req_busy), 32'd0);
    chk({name, "_done"}, 32'(req_done), 32'd0);
    chk({name, "_err"}, 32'(req_err), 32'd0);
    chk({name, "_res"}, res, 32'd0);
    chk({name, "_add_ri"}, 32'(add_ri), 32'd0);
    chk({name, "_add_a"}, add_a, 32'd0);
    chk({name, "_add_b"}, add_b, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n0, d0, idx, k;
  bit got;

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_quiet("reset");
    tick(); reset = 1'b0;

    // single request, latency 5
    lat_fixed = 5;
    set_ops(0, FP_ONE, 32'h4000_0000);
    n0 = n_issue; d0 = done_cnt[0];
    pulse(4'b0001);
    wait_idle("single", 100);
    chk("single_issues", 32'(n_issue - n0), 32'd1);
    chk("single_res", last_res, 32'h4040_0000);
    chk("single_done", 32'(done_cnt[0] - d0), 32'd1);

    // all four at once after a fresh reset: order 0,1,2,3
    do_reset();
    lat_fixed = 0;
    for (int i = 0; i < N; i++) set_ops(i, FP_ONE, FP_ONE);
    done_log.delete();
    n0 = n_issue;
    pulse(4'b1111);
    wait_idle("all4", 200);
    chk("all4_issues", 32'(n_issue - n0), 32'd4);
    chk("all4_count", 32'(done_log.size()), 32'd4);
    for (int i = 0; i < N && i < done_log.size(); i++) chk("all4_order", 32'(done_log[i]), 32'(i));
    chk("all4_res", last_res, 32'h4000_0000);

    // fairness: 0 and 1 re-request right after each done
    done_log.delete();
    set_ops(0, $urandom, $urandom);
    set_ops(1, $urandom, $urandom);
    pulse(4'b0011);
    for (int g = 0; g < 20; g++) begin
      got = 0;
      for (k = 0; k < 100 && !got; k++) begin
        @(negedge clk);
        if (req_done[0] || req_done[1]) got = 1;
      end
      chk("fair_done_timeout", 32'(got), 32'd1);
      if (!got) break;
      idx = req_done[1] ? 1 : 0;
      if (g < 18) begin
        set_ops(idx, $urandom, $urandom);
        tick(); req_ri[idx] = 1'b1;
        tick(); req_ri = '0;
      end
    end
    wait_idle("fair", 200);
    chk("fair_count", 32'(done_log.size()), 32'd20);
    for (int i = 1; i < done_log.size(); i++) chk("fair_alternate", 32'(done_log[i]), 32'(1 - done_log[i-1]));

    // busy drop: second pulse of requester 2 must be ignored
    lat_fixed = 6;
    set_ops(2, 32'h1111_2222, 32'h3333_4444);
    d0 = done_cnt[2];
    pulse(4'b0100);
    set_ops(2, 32'hAAAA_BBBB, 32'hCCCC_DDDD);
    pulse(4'b0100);
    wait_idle("busydrop", 100);
    chk("busydrop_done", 32'(done_cnt[2] - d0), 32'd1);
    chk("busydrop_res", last_res, fadd(32'h1111_2222, 32'h3333_4444));

    // randomized traffic
    lat_fixed = 0;
    for (int c = 0; c < 300; c++) begin
      tick();
      if ($urandom_range(0, 3) == 0) begin
        for (int i = 0; i < N; i++) set_ops(i, $urandom, $urandom);
        req_ri = N'($urandom);
      end else begin
        req_ri = '0;
      end
    end
    tick(); req_ri = '0;
    wait_idle("random", 3000);

    // reset while waiting, then a stray add_ro
    adder_mute = 1;
    set_ops(3, 32'h0BAD_F00D, 32'h1234_5678);
    n0 = n_issue; d0 = n_done;
    pulse(4'b1000);
    for (k = 0; k < 20 && n_issue == n0; k++) @(negedge clk);
    chk("rst_issue_seen", 32'(n_issue - n0), 32'd1);
    repeat (3) @(negedge clk);
    tick(); reset = 1'b1;
    tick(); reset = 1'b0;
    stray_req = 1;
    repeat (4) @(negedge clk);
    check_quiet("after_rst");
    chk("after_rst_no_done", 32'(n_done - d0), 32'd0);

    // adder never answers
    set_ops(1, 32'h7777_0001, 32'h0000_8888);
    n0 = n_issue; d0 = n_done; k = n_err;
    pulse(4'b0010);
`ifdef SUM_SHARE_ARB_TIMEOUT_EN
    wait_idle("timeout", 100);
    chk("timeout_done", 32'(n_done - d0), 32'd1);
    chk("timeout_err", 32'(n_err - k), 32'd1);
    chk("timeout_res", last_res, FP_ZERO);
`else
    repeat (100) @(negedge clk);
    chk("stuck_issues", 32'(n_issue - n0), 32'd1);
    chk("stuck_no_done", 32'(n_done - d0), 32'd0);
    chk("stuck_busy", 32'(req_busy), 32'b0010);
    chk("stuck_no_err", 32'(n_err - k), 32'd0);
    tick(); reset = 1'b1;
    tick(); reset = 1'b0;
`endif
    adder_mute = 0;

    // normal service resumes
    lat_fixed = 3;
    set_ops(2, FP_ONE, 32'h4000_0000);
    d0 = done_cnt[2];
    pulse(4'b0100);
    wait_idle("resume", 100);
    chk("resume_done", 32'(done_cnt[2] - d0), 32'd1);
    chk("resume_res", last_res, 32'h4040_0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
